// File: rtl/hdec_pkg.sv
// hdec_pkg: code table, widths and state type shared by the streaming Huffman decoder
package hdec_pkg;
    localparam int MAX_LEN   = 6;
    localparam int SYM_W     = 4;
    localparam int NUM_CODES = 14;
    localparam int LEN_W     = $clog2(MAX_LEN + 1);

    // code is left-aligned in MAX_LEN bits; bits below len are zero
    typedef struct packed {
        logic [MAX_LEN-1:0] code;
        logic [LEN_W-1:0]   len;
        logic [SYM_W-1:0]   sym;
    } code_entry_t;

    localparam code_entry_t CODE_TABLE [NUM_CODES] = '{
        '{6'b100000, 3'd1, 4'd0},
        '{6'b010000, 3'd4, 4'd1},
        '{6'b010100, 3'd4, 4'd2},
        '{6'b011000, 3'd6, 4'd3},
        '{6'b011001, 3'd6, 4'd4},
        '{6'b001000, 3'd4, 4'd5},
        '{6'b001100, 3'd4, 4'd6},
        '{6'b011010, 3'd5, 4'd7},
        '{6'b000110, 3'd6, 4'd8},
        '{6'b011100, 3'd4, 4'd9},
        '{6'b000000, 3'd4, 4'd10},
        '{6'b000111, 3'd6, 4'd12},
        '{6'b000100, 3'd6, 4'd14},
        '{6'b000101, 3'd6, 4'd15}
    };

    typedef enum logic [1:0] {RUN, DRAIN, ERR} state_t;
endpackage

// File: rtl/hdec_match.sv
// hdec_match: parallel compare of the buffer window against every table entry
module hdec_match
    import hdec_pkg::*;
#(
    parameter int FILL_W = 4
) (
    input  logic [MAX_LEN-1:0] win_i,
    input  logic [FILL_W-1:0]  fill_i,
    output logic               hit_o,
    output logic [SYM_W-1:0]   sym_o,
    output logic [LEN_W-1:0]   len_o
);
    // prefix-free table: at most one entry hits, so results are OR-merged
    always_comb begin
        hit_o = 1'b0;
        sym_o = '0;
        len_o = '0;
        for (int i = 0; i < NUM_CODES; i++) begin
            if ((((win_i ^ CODE_TABLE[i].code) & ~({MAX_LEN{1'b1}} >> CODE_TABLE[i].len)) == '0)
                && (FILL_W'(CODE_TABLE[i].len) <= fill_i)) begin
                hit_o = 1'b1;
                sym_o = sym_o | CODE_TABLE[i].sym;
                len_o = len_o | CODE_TABLE[i].len;
            end
        end
    end
endmodule

// File: rtl/hdec_stream.sv
// hdec_stream: streaming Huffman decoder with sliding bit buffer and valid/ready on both sides
module hdec_stream
    import hdec_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [DATA_W-1:0]           in_data_i,
    input  logic                        in_valid_i,
    input  logic                        in_last_i,
    input  logic [$clog2(DATA_W+1)-1:0] in_nbits_i,
    output logic                        in_ready_o,
    output logic [SYM_W-1:0]            out_sym_o,
    output logic [LEN_W-1:0]            out_len_o,
    output logic                        out_valid_o,
    output logic                        out_last_o,
    input  logic                        out_ready_i,
    output logic                        err_o
);
    localparam int BUF_W  = DATA_W + MAX_LEN;
    localparam int FILL_W = $clog2(BUF_W + 1);

    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [FILL_W-1:0] fill_q, fill_d, fill_s, nb;
    state_t            state_q, state_d;
    logic              rdy_q, out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [SYM_W-1:0]  sym_q, sym_d, m_sym;
    logic [LEN_W-1:0]  len_q, len_d, m_len;
    logic              hit, acc, en, load, bad;
    logic [DATA_W-1:0] word;

    hdec_match #(.FILL_W(FILL_W)) u_match (
        .win_i  (buf_q[BUF_W-1 -: MAX_LEN]),
        .fill_i (fill_q),
        .hit_o  (hit),
        .sym_o  (m_sym),
        .len_o  (m_len)
    );

    assign in_ready_o = rdy_q && state_q == RUN && fill_q <= FILL_W'(BUF_W - DATA_W);
    assign acc        = in_valid_i && in_ready_o;
    assign en         = state_q == RUN ? fill_q >= FILL_W'(MAX_LEN) : state_q == DRAIN && fill_q != '0;
    assign load       = en && hit && (!out_valid_q || out_ready_i);
    assign bad        = en && !hit;
    assign nb         = in_last_i && in_nbits_i != '0 ? FILL_W'(in_nbits_i) : FILL_W'(DATA_W);
    assign fill_s     = load ? fill_q - FILL_W'(m_len) : fill_q;
    // bits beyond fill stay zero so appended words can simply be OR-ed in
    assign word       = in_data_i & ~({DATA_W{1'b1}} >> nb);

    always_comb begin
        buf_d       = (load ? buf_q << m_len : buf_q) | (acc ? {word, {MAX_LEN{1'b0}}} >> fill_s : '0);
        fill_d      = fill_s + (acc ? nb : '0);
        state_d     = state_q == RUN   ? (bad ? ERR : acc && in_last_i ? DRAIN : RUN) :
                      state_q == DRAIN ? (bad ? ERR : out_valid_q && out_ready_i && out_last_q ? RUN : DRAIN) :
                      ERR;
        out_valid_d = load || (out_valid_q && !out_ready_i);
        sym_d       = load ? m_sym : sym_q;
        len_d       = load ? m_len : len_q;
        out_last_d  = load ? state_q == DRAIN && fill_s == '0 : out_last_q && !(out_valid_q && out_ready_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q       <= '0;
            fill_q      <= '0;
            state_q     <= RUN;
            rdy_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sym_q       <= '0;
            len_q       <= '0;
        end else begin
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            state_q     <= state_d;
            rdy_q       <= 1'b1;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            sym_q       <= sym_d;
            len_q       <= len_d;
        end
    end

    assign out_sym_o   = sym_q;
    assign out_len_o   = len_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign err_o       = state_q == ERR;
endmodule
